// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 UART receiver, LSB first.
// Ports: clk, rst (async, active-high), br_tick (16x baud strobe),
//   rx (async serial line, idle high), rx_data (last good byte),
//   rx_done (1-cycle pulse, rx_data valid), frame_err (1-cycle pulse
//   on a low stop bit), rx_busy (receiver not idle).
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over
//   the three br_tick samples ending at each decision tick.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    localparam logic [3:0] START_DEC = 4'd7;
    localparam logic [3:0] BIT_DEC   = 4'd15;

    // Synchronizer for the asynchronous rx pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [3:0]           tick_q;
    logic [3:0]           tick_d;
    logic [BCW-1:0]       bit_q;
    logic [BCW-1:0]       bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 done_q;
    logic                 done_d;
    logic                 err_q;
    logic                 err_d;

    logic bit_val;

    always_comb begin
        // Shift towards the MSB; the truncating cast keeps the newest
        // SYNC_STAGES samples and also covers a single-stage chain.
        sync_d = SYNC_STAGES'({sync_q, rx});
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The two previous tick samples; together with the live rx_s at the
    // decision tick they form the D-2/D-1/D window.
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = hist_q;
        if (br_tick) begin
            hist_d = {hist_q[0], rx_s};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & rx_s) |
                     (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (br_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        tick_d  = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_q == START_DEC) begin
                        if (!bit_val) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            // Too short to be a start bit
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    // 4-bit counter wraps 15->0 on the decision tick
                    tick_d = tick_q + 4'd1;
                    if (tick_q == BIT_DEC) begin
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == BIT_DEC) begin
                        if (bit_val) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // Hold off in BRK so a stuck-low line
                            // reports a single framing error.
                            err_d   = 1'b1;
                            state_d = BRK;
                        end
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames for uart_rx, checked against
// frame-level expectations (good frames deliver their byte, bad ones don't).
module tb_uart_rx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       br_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic busy_seen = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .br_tick(br_tick),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (rx_busy) busy_seen = 1'b1;
            if (rx_done || frame_err) begin
                chk("excl", {30'd0, rx_done, frame_err} & 32'h3 &
                    {30'd0, frame_err, rx_done}, 32'd0);
            end
            if (rx_done) begin
                done_cnt++;
                got_q.push_back(rx_data);
                chk("busy_at_done", {31'd0, rx_busy}, 32'd0);
            end
            if (frame_err) err_cnt++;
            if (prev_done) chk("done_width", {31'd0, rx_done}, 32'd0);
            if (prev_err) chk("err_width", {31'd0, frame_err}, 32'd0);
            prev_done = rx_done;
            prev_err = frame_err;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            repeat (DIV - 1) @(negedge clk);
            br_tick = 1'b1;
            @(negedge clk);
            br_tick = 1'b0;
        end
    endtask

    // One bit period; a glitch drives the line high for the single
    // tick period that lands on the mid-bit sample.
    task automatic send_bit(input logic lvl, input bit glitch);
        rx = lvl;
        if (glitch) begin
            tick_n(8);
            rx = 1'b1;
            tick_n(1);
            rx = lvl;
            tick_n(7);
        end else begin
            tick_n(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], i == gbit);
        send_bit(stop, 1'b0);
        rx = 1'b1;
    endtask

    function automatic logic [7:0] last_got();
        if (got_q.size() == 0) return 8'hxx;
        return got_q[got_q.size()-1];
    endfunction

    initial begin
        int d0;
        int e0;
        int base;
        int nerr;
        logic [7:0] b;
        logic [7:0] gexp;

        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        tick_n(4);

        send_frame(8'h55, 1'b1, -1);
        tick_n(4);
        chk("n55", done_cnt, 1);
        chk("d55", {24'd0, last_got()}, 32'h55);
        chk("e55", err_cnt, 0);
        chk("busy55", {31'd0, rx_busy}, 32'd0);

        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        tick_n(4);
        chk("n_b2b", done_cnt, 3);
        chk("dA3", {24'd0, got_q[1]}, 32'hA3);
        chk("d00", {24'd0, got_q[2]}, 32'h00);

        d0 = done_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        tick_n(3);
        rx = 1'b1;
        tick_n(16);
        chk("glitch_done", done_cnt, d0);
        chk("glitch_err", err_cnt, e0);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("glitch_busy_end", {31'd0, rx_busy}, 32'd0);

        send_frame(8'h11, 1'b1, -1);
        tick_n(2);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        tick_n(20 * 16);
        chk("brk_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        tick_n(4);
        chk("fe_count", err_cnt - e0, 1);
        chk("fe_nodone", done_cnt - d0, 0);
        chk("fe_hold", {24'd0, rx_data}, 32'h11);
        chk("fe_busy", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h7E, 1'b1, -1);
        tick_n(2);
        chk("d7E", {24'd0, rx_data}, 32'h7E);

        b = 8'hF0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        rx = b[4];
        tick_n(8);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, rx_done}, 32'd0);
        chk("mid_rst_err", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        tick_n(2);
        rst = 1'b0;
        tick_n(4);
        d0 = done_cnt;
        send_frame(8'h9C, 1'b1, -1);
        tick_n(2);
        chk("n9C", done_cnt - d0, 1);
        chk("d9C", {24'd0, rx_data}, 32'h9C);

`ifdef UART_RX_MAJORITY_EN
        gexp = 8'h00;
`else
        gexp = 8'h04;
`endif
        send_frame(8'h00, 1'b1, 2);
        tick_n(2);
        chk("bit_glitch", {24'd0, rx_data}, {24'd0, gexp});

        base = got_q.size();
        e0 = err_cnt;
        nerr = 0;
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, 1'b0, -1);
                rx = 1'b0;
                tick_n($urandom_range(0, 40));
                rx = 1'b1;
                tick_n(2);
                nerr++;
            end else begin
                send_frame(b, 1'b1, -1);
                exp_q.push_back(b);
            end
            tick_n($urandom_range(0, 24));
        end
        tick_n(4);
        chk("rnd_count", got_q.size() - base, exp_q.size());
        chk("rnd_errs", err_cnt - e0, nerr);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                chk("rnd_data", {24'd0, got_q[base+i]},
                    {24'd0, exp_q[i]});
        end
        if (exp_q.size() > 0)
            chk("rnd_last", {24'd0, rx_data},
                {24'd0, exp_q[exp_q.size()-1]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
